// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and control bundle for the multi-cycle MIPS controller.
package mips_ctrl_pkg;

    localparam int unsigned OPC_W = 6;
    localparam int unsigned FUN_W = 6;
    localparam int unsigned ALU_W = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FUN_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUN_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [FUN_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUN_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FUN_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUN_W-1:0] FN_XOR  = 6'b100110;
    localparam logic [FUN_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [FUN_W-1:0] FN_SLL  = 6'b000000;
    localparam logic [FUN_W-1:0] FN_SRL  = 6'b000010;
    localparam logic [FUN_W-1:0] FN_SRA  = 6'b000011;
    localparam logic [FUN_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUN_W-1:0] FN_SEQ  = 6'b101001;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SEQ = 4'b1010;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       is_imm_unsigned;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode/funct to ALU operation, immediate extension mode and legality.
module alu_op_decode
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OP_W   = 6,
    parameter int unsigned FN_W   = 6,
    parameter int unsigned ALUC_W = 4
) (
    input  logic [OP_W-1:0]   opcode_i,
    input  logic [FN_W-1:0]   funct_i,
    output logic [ALUC_W-1:0] alu_control_o,
    output logic              imm_unsigned_o,
    output logic              legal_o
);

    logic [ALU_W-1:0] code;

    always_comb begin
        code           = ALU_ADD;
        imm_unsigned_o = 1'b0;
        legal_o        = 1'b1;
        case (opcode_i)
            OP_W'(OP_RTYPE): begin
                case (funct_i)
                    FN_W'(FN_ADD), FN_W'(FN_ADDU): code = ALU_ADD;
                    FN_W'(FN_SUB):                 code = ALU_SUB;
                    FN_W'(FN_AND):                 code = ALU_AND;
                    FN_W'(FN_OR):                  code = ALU_OR;
                    FN_W'(FN_XOR):                 code = ALU_XOR;
                    FN_W'(FN_NOR):                 code = ALU_NOR;
                    FN_W'(FN_SLL):                 code = ALU_SLL;
                    FN_W'(FN_SRL):                 code = ALU_SRL;
                    FN_W'(FN_SRA):                 code = ALU_SRA;
                    FN_W'(FN_SLT):                 code = ALU_SLT;
                    FN_W'(FN_SEQ):                 code = ALU_SEQ;
                    default:                       legal_o = 1'b0;
                endcase
            end
            OP_W'(OP_J), OP_W'(OP_ADDI), OP_W'(OP_LW), OP_W'(OP_SW): code = ALU_ADD;
            OP_W'(OP_BEQ): code = ALU_SUB;
            OP_W'(OP_ANDI): begin
                code           = ALU_AND;
                imm_unsigned_o = 1'b1;
            end
            OP_W'(OP_ORI): begin
                code           = ALU_OR;
                imm_unsigned_o = 1'b1;
            end
            OP_W'(OP_XORI): begin
                code           = ALU_XOR;
                imm_unsigned_o = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

    assign alu_control_o = ALUC_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM with memory ready handshake, illegal-instruction and wait-timeout traps.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OP_W     = 6,
    parameter int unsigned FN_W     = 6,
    parameter int unsigned ALUC_W   = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FN_W-1:0]   funct,
    input  logic              mem_ready,
    input  logic              alu_zero,
    output logic              ir_write,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUC_W-1:0] alu_control,
    output logic              is_imm_unsigned,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              illegal_instr,
    output logic              mem_timeout,
    output logic [2:0]        state_o
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [FN_W-1:0]  fn_q, fn_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic [OP_W-1:0]   dec_op;
    logic [FN_W-1:0]   dec_fn;
    logic [ALUC_W-1:0] dec_alu;
    logic              dec_imm_uns, dec_legal;
    logic              is_rtype, is_j, is_beq, is_lw, is_sw;
    logic              mem_wait, timeout_hit;
    ctrl_t             ctl, ctl_g;
    logic [ALUC_W-1:0] alu_c;

    // DECODE sees the live IR fields; later states use the copy latched in DECODE.
    assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;
    assign dec_fn = (state_q == ST_DECODE) ? funct  : fn_q;

    alu_op_decode #(.OP_W(OP_W), .FN_W(FN_W), .ALUC_W(ALUC_W)) u_dec (
        .opcode_i       (dec_op),
        .funct_i        (dec_fn),
        .alu_control_o  (dec_alu),
        .imm_unsigned_o (dec_imm_uns),
        .legal_o        (dec_legal)
    );

    assign is_rtype    = (dec_op == OP_W'(OP_RTYPE));
    assign is_j        = (dec_op == OP_W'(OP_J));
    assign is_beq      = (dec_op == OP_W'(OP_BEQ));
    assign is_lw       = (dec_op == OP_W'(OP_LW));
    assign is_sw       = (dec_op == OP_W'(OP_SW));
    assign timeout_hit = (MAX_WAIT != 0) && (cnt_q == CNT_W'(MAX_WAIT));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        fn_d      = fn_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        ctl       = '0;
        alu_c     = '0;
        mem_wait  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = 2'd1;
                alu_c         = ALUC_W'(ALU_ADD);
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = ST_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            ST_DECODE: begin
                op_d          = opcode;
                fn_d          = funct;
                ctl.alu_src_b = 2'd3;
                alu_c         = ALUC_W'(ALU_ADD);
                if (is_j) begin
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = 2'd2;
                    state_d      = ST_FETCH;
                end else if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                ctl.alu_src_a = 1'b1;
                alu_c         = dec_alu;
                if (is_rtype) begin
                    state_d = ST_WB;
                end else if (is_beq) begin
                    ctl.pc_write = alu_zero;
                    ctl.pc_src   = 2'd1;
                    state_d      = ST_FETCH;
                end else begin
                    ctl.alu_src_b       = 2'd2;
                    ctl.is_imm_unsigned = dec_imm_uns;
                    state_d             = (is_lw || is_sw) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                ctl.i_or_d    = 1'b1;
                ctl.mem_read  = is_lw;
                ctl.mem_write = is_sw;
                if (mem_ready) begin
                    state_d = is_lw ? ST_WB : ST_FETCH;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            ST_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = is_rtype;
                ctl.mem_to_reg = is_lw;
                state_d        = ST_FETCH;
            end
            ST_TRAP: ;
            default: state_d = ST_FETCH;
        endcase

        // A ready on the final allowed wait cycle completes the access instead of trapping.
        if (mem_wait && timeout_hit) begin
            state_d   = ST_TRAP;
            timeout_d = 1'b1;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_wait) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            op_q      <= '0;
            fn_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Reset forces every output low, including the FETCH read request.
    assign ctl_g           = rst ? '0 : ctl;
    assign alu_control     = rst ? '0 : alu_c;
    assign state_o         = rst ? 3'd0 : state_q;
    assign ir_write        = ctl_g.ir_write;
    assign pc_write        = ctl_g.pc_write;
    assign pc_src          = ctl_g.pc_src;
    assign alu_src_a       = ctl_g.alu_src_a;
    assign alu_src_b       = ctl_g.alu_src_b;
    assign is_imm_unsigned = ctl_g.is_imm_unsigned;
    assign i_or_d          = ctl_g.i_or_d;
    assign mem_read        = ctl_g.mem_read;
    assign mem_write       = ctl_g.mem_write;
    assign reg_write       = ctl_g.reg_write;
    assign reg_dst         = ctl_g.reg_dst;
    assign mem_to_reg      = ctl_g.mem_to_reg;
    assign illegal_instr   = illegal_q;
    assign mem_timeout     = timeout_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expectations queued and compared at the falling edge.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       alu_zero;
    logic       ir_write, pc_write, alu_src_a, is_imm_unsigned, i_or_d;
    logic       mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
    logic       illegal_instr, mem_timeout;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] state_o;

    multicycle_controller #(.OP_W(6), .FN_W(6), .ALUC_W(4), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .alu_zero(alu_zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .is_imm_unsigned(is_imm_unsigned), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .state_o(state_o)
    );

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [17:0] ctl;
        logic        ill;
        logic        tmo;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        exp_ill  = 1'b0;
    logic        exp_tmo  = 1'b0;
    logic [17:0] ctl_obs;

    assign ctl_obs = {ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_control,
                      is_imm_unsigned, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] mk(input logic ir, input logic pcw, input logic [1:0] pcs,
                                       input logic sa, input logic [1:0] sbs, input logic [3:0] alu,
                                       input logic imm, input logic iord, input logic mr, input logic mw,
                                       input logic rw, input logic rd, input logic m2r);
        return {ir, pcw, pcs, sa, sbs, alu, imm, iord, mr, mw, rw, rd, m2r};
    endfunction

    function automatic logic [17:0] c_fetch(input logic rdy);
        return mk(rdy, rdy, 2'd0, 1'b0, 2'd1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [17:0] c_dec();
        return mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic push(input string tag, input logic [2:0] st, input logic [17:0] c);
        exp_t e;
        e.tag = tag; e.st = st; e.ctl = c; e.ill = exp_ill; e.tmo = exp_tmo;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty at %0t", $time);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (state_o === e.st) else begin
            failures++;
            $error("FAIL %s state: got %0d expected %0d", e.tag, state_o, e.st);
        end
        checks++;
        assert (ctl_obs === e.ctl) else begin
            failures++;
            $error("FAIL %s ctl: got %b expected %b", e.tag, ctl_obs, e.ctl);
        end
        checks++;
        assert ({illegal_instr, mem_timeout} === {e.ill, e.tmo}) else begin
            failures++;
            $error("FAIL %s flags(ill,tmo): got %b%b expected %b%b",
                   e.tag, illegal_instr, mem_timeout, e.ill, e.tmo);
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, return at next posedge+1.
    task automatic step(input string tag, input logic rdy, input logic z,
                        input logic [2:0] st, input logic [17:0] c);
        mem_ready = rdy;
        alu_zero  = z;
        push(tag, st, c);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        exp_ill   = 1'b0;
        exp_tmo   = 1'b0;
        #2;
        push("in_reset", 3'd0, 18'd0);
        check_now();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic run_alu(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic [3:0] alu, input logic imm);
        logic r;
        r      = (op == 6'b000000);
        opcode = op;
        funct  = fn;
        step({tag, "_fetch"}, 1'b1, 1'b0, 3'd0, c_fetch(1'b1));
        step({tag, "_decode"}, 1'b0, 1'b0, 3'd1, c_dec());
        step({tag, "_exec"}, 1'b0, 1'b1, 3'd2,
             mk(1'b0, 1'b0, 2'd0, 1'b1, r ? 2'd0 : 2'd2, alu, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step({tag, "_wb"}, 1'b0, 1'b0, 3'd4,
             mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, r, 1'b0));
    endtask

    task automatic run_beq(input logic z);
        opcode = 6'b000100;
        funct  = 6'b000000;
        step("beq_fetch", 1'b1, 1'b0, 3'd0, c_fetch(1'b1));
        step("beq_decode", 1'b0, 1'b0, 3'd1, c_dec());
        step(z ? "beq_taken" : "beq_not_taken", 1'b0, z, 3'd2,
             mk(1'b0, z, 2'd1, 1'b1, 2'd0, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic run_trap(input string tag, input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        step({tag, "_fetch"}, 1'b1, 1'b0, 3'd0, c_fetch(1'b1));
        step({tag, "_decode"}, 1'b0, 1'b0, 3'd1, c_dec());
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++) step({tag, "_trap"}, 1'b1, 1'b1, 3'd5, 18'd0);
        do_reset();
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; alu_zero = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // add, zero-wait: 0,1,2,4 then back to FETCH (which is checked waiting)
        run_alu("add", 6'b000000, 6'b100000, 4'b0010, 1'b0);
        step("after_add", 1'b0, 1'b0, 3'd0, c_fetch(1'b0));

        // lw with three wait cycles in MEM
        opcode = 6'b100011;
        step("lw_fetch", 1'b1, 1'b0, 3'd0, c_fetch(1'b1));
        step("lw_decode", 1'b0, 1'b0, 3'd1, c_dec());
        step("lw_exec", 1'b0, 1'b0, 3'd2,
             mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            step("lw_mem", (i == 3), 1'b0, 3'd3,
                 mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step("lw_wb", 1'b0, 1'b0, 3'd4,
             mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));

        // sw, zero-wait
        opcode = 6'b101011;
        step("sw_fetch", 1'b1, 1'b0, 3'd0, c_fetch(1'b1));
        step("sw_decode", 1'b0, 1'b0, 3'd1, c_dec());
        step("sw_exec", 1'b0, 1'b0, 3'd2,
             mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("sw_mem", 1'b1, 1'b0, 3'd3,
             mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

        run_alu("sub",  6'b000000, 6'b100010, 4'b0011, 1'b0);
        run_alu("or",   6'b000000, 6'b100101, 4'b0001, 1'b0);
        run_alu("nor",  6'b000000, 6'b100111, 4'b0101, 1'b0);
        run_alu("sll",  6'b000000, 6'b000000, 4'b0110, 1'b0);
        run_alu("sra",  6'b000000, 6'b000011, 4'b1000, 1'b0);
        run_alu("slt",  6'b000000, 6'b101010, 4'b1001, 1'b0);
        run_alu("addi", 6'b001000, 6'b111111, 4'b0010, 1'b0);
        run_alu("andi", 6'b001100, 6'b000000, 4'b0000, 1'b1);
        run_alu("ori",  6'b001101, 6'b000000, 4'b0001, 1'b1);
        run_alu("xori", 6'b001110, 6'b000000, 4'b0100, 1'b1);

        run_beq(1'b1);
        run_beq(1'b0);

        opcode = 6'b000010;
        step("j_fetch", 1'b1, 1'b0, 3'd0, c_fetch(1'b1));
        step("j_decode", 1'b0, 1'b0, 3'd1,
             mk(1'b0, 1'b1, 2'd2, 1'b0, 2'd3, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // ready arriving on the 16th wait cycle still completes the fetch
        for (int i = 0; i < 15; i++) step("tw_wait", 1'b0, 1'b0, 3'd0, c_fetch(1'b0));
        step("tw_ready_wins", 1'b1, 1'b0, 3'd0, c_fetch(1'b1));
        step("tw_decode", 1'b0, 1'b0, 3'd1,
             mk(1'b0, 1'b1, 2'd2, 1'b0, 2'd3, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // 16 wait cycles without ready -> timeout trap
        for (int i = 0; i < 16; i++) step("to_wait", 1'b0, 1'b0, 3'd0, c_fetch(1'b0));
        exp_tmo = 1'b1;
        for (int i = 0; i < 4; i++) step("to_trap", i[0], 1'b1, 3'd5, 18'd0);
        do_reset();

        run_trap("ill_op", 6'b111111, 6'b100000);
        run_trap("ill_fn", 6'b000000, 6'b001111);

        // asynchronous reset in the middle of a stalled store
        opcode = 6'b101011;
        step("swr_fetch", 1'b1, 1'b0, 3'd0, c_fetch(1'b1));
        step("swr_decode", 1'b0, 1'b0, 3'd1, c_dec());
        step("swr_exec", 1'b0, 1'b0, 3'd2,
             mk(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step("swr_mem", 1'b0, 1'b0, 3'd3,
             mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        #2;
        push("swr_mem_hold", 3'd3,
             mk(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        check_now();
        rst = 1'b1;
        #1;
        push("swr_async_rst", 3'd0, 18'd0);
        check_now();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst_fetch", 1'b0, 1'b0, 3'd0, c_fetch(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
